// File: rtl/spi_acq_sequencer.sv
// spi_acq_sequencer
//   Run controller for the SPI result-register reader. It gates the SPI master
//   enable and packs the received bytes of each transfer into one frame. Frames
//   are queued in a small FIFO and leave on an AXI-Stream master, one beat per
//   frame. It also provides run-length control, back-pressure, a transfer
//   watchdog and sticky error flags.
//
//   Optional feature: define SPI_ACQ_TIMESTAMP_EN to prepend a 32-bit capture
//   of a free-running cycle counter to every frame. The counter is captured
//   when a transfer is seen to start. Without the macro no counter logic exists.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_start, i_stop         run control pulses
//   i_num_frames            frames per run (0 = continuous), sampled at start
//   o_spi_en                enable to the SPI master
//   o_spi_buffer_full       back-pressure to the SPI master
//   i_spi_ready             SPI master idle level; a falling edge marks a transfer start
//   i_rx_byte_valid_tick    RX byte strobe, with i_rx_byte
//   i_transfer_done_tick    end-of-transfer strobe
//   m_axis_*                frame output stream (tdata, tvalid, tlast, tready)
//   o_busy                  sequencer not idle
//   o_frame_count           frames pushed this run
//   o_err_timeout, o_err_len  sticky error flags, cleared by i_start
module spi_acq_sequencer #(
  parameter int BYTES_PER_XFER = 6,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int DW = 8 * BYTES_PER_XFER,
`ifdef SPI_ACQ_TIMESTAMP_EN
  localparam int FW = DW + 32
`else
  localparam int FW = DW
`endif
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic [15:0]   i_num_frames,
  output logic          o_spi_en,
  output logic          o_spi_buffer_full,
  input  logic          i_spi_ready,
  input  logic          i_rx_byte_valid_tick,
  input  logic [7:0]    i_rx_byte,
  input  logic          i_transfer_done_tick,
  output logic [FW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  output logic          m_axis_tlast,
  input  logic          m_axis_tready,
  output logic          o_busy,
  output logic [15:0]   o_frame_count,
  output logic          o_err_timeout,
  output logic          o_err_len
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BCW = $clog2(BYTES_PER_XFER + 2);
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BCW-1:0] BYTE_SAT = BCW'(BYTES_PER_XFER + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_ERROR} state_t;

  state_t          state, state_next;
  logic            spi_ready_q;
  logic            inflight;
  logic [BCW-1:0]  byte_cnt, byte_cnt_eff;
  logic [DW-1:0]   shift_reg, shift_eff;
  logic [WDW-1:0]  wd_cnt;
  logic [15:0]     num_frames_q;
  logic [15:0]     frame_count;
  logic            err_timeout, err_len;
  logic            buf_full_q;

  logic [FW:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   fifo_count;

  logic            go, xfer_active, ready_fall, start_xfer, take_byte;
  logic            xfer_done, len_ok, timeout, fifo_full, fifo_empty;
  logic            push, pop, push_last, limit_reached, frames_left, flush;
  logic [FW-1:0]   push_data;

`ifdef SPI_ACQ_TIMESTAMP_EN
  logic [31:0]     ts_cnt, ts_cap;
`endif

  // A transfer starts when the registered ready level sees the master go busy.
  // Ready is registered as 0 in reset so a transfer already running when reset
  // is released is ignored until the next genuine falling edge.
  always_comb begin
    go            = i_start && (state == ST_IDLE || state == ST_ERROR);
    xfer_active   = (state == ST_RUN) || (state == ST_DRAIN);
    ready_fall    = spi_ready_q && !i_spi_ready;
    start_xfer    = ready_fall && xfer_active;
    take_byte     = i_rx_byte_valid_tick && (inflight || start_xfer);
    byte_cnt_eff  = (take_byte && byte_cnt != BYTE_SAT) ? byte_cnt + BCW'(1) : byte_cnt;
    shift_eff     = take_byte ? DW'({shift_reg, i_rx_byte}) : shift_reg;
    xfer_done     = i_transfer_done_tick && inflight;
    len_ok        = (byte_cnt_eff == BCW'(BYTES_PER_XFER));
    timeout       = inflight && !i_transfer_done_tick && (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));
    fifo_full     = (fifo_count == CW'(FIFO_DEPTH));
    fifo_empty    = (fifo_count == '0);
    push          = xfer_done && len_ok && !fifo_full;
    pop           = !fifo_empty && m_axis_tready;
    flush         = timeout || (state == ST_ERROR);
    push_last     = (num_frames_q != 16'd0) && ((frame_count + 16'd1) == num_frames_q);
    limit_reached = (num_frames_q != 16'd0) && (frame_count >= num_frames_q);
    frames_left   = (num_frames_q == 16'd0) ||
                    (({1'b0, frame_count} + {16'b0, inflight}) < {1'b0, num_frames_q});
`ifdef SPI_ACQ_TIMESTAMP_EN
    push_data     = {ts_cap, shift_eff};
`else
    push_data     = shift_eff;
`endif
  end

  // Run state machine. The watchdog wins from RUN or DRAIN; DRAIN waits until the
  // master is idle, nothing is in flight and every queued frame has left.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (i_start) state_next = ST_RUN;
      ST_RUN: begin
        if (timeout)                      state_next = ST_ERROR;
        else if (i_stop || limit_reached) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (timeout)                                       state_next = ST_ERROR;
        else if (!inflight && fifo_empty && i_spi_ready)   state_next = ST_IDLE;
      end
      ST_ERROR: if (i_start) state_next = ST_RUN;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Control state: transfer tracking, byte assembly, watchdog, run counters and
  // sticky errors. Buffer-full is registered from the current FIFO occupancy plus
  // the in-flight slot so a started transfer always has room reserved.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      spi_ready_q  <= 1'b0;
      inflight     <= 1'b0;
      byte_cnt     <= '0;
      shift_reg    <= '0;
      wd_cnt       <= '0;
      num_frames_q <= 16'd0;
      frame_count  <= 16'd0;
      err_timeout  <= 1'b0;
      err_len      <= 1'b0;
      buf_full_q   <= 1'b0;
    end else begin
      state       <= state_next;
      spi_ready_q <= i_spi_ready;
      buf_full_q  <= ({1'b0, fifo_count} + {{CW{1'b0}}, inflight}) >= (CW + 1)'(FIFO_DEPTH);

      if (timeout)         inflight <= 1'b0;
      else if (start_xfer) inflight <= 1'b1;
      else if (xfer_done)  inflight <= 1'b0;

      if (!inflight || xfer_done || timeout) wd_cnt <= '0;
      else                                   wd_cnt <= wd_cnt + WDW'(1);

      if (timeout || xfer_done) begin
        byte_cnt  <= '0;
        shift_reg <= '0;
      end else if (take_byte) begin
        byte_cnt  <= byte_cnt_eff;
        shift_reg <= shift_eff;
      end

      if (go) begin
        num_frames_q <= i_num_frames;
        frame_count  <= 16'd0;
        err_timeout  <= 1'b0;
        err_len      <= 1'b0;
      end else begin
        if (push)                  frame_count <= frame_count + 16'd1;
        if (timeout)               err_timeout <= 1'b1;
        if (xfer_done && !len_ok)  err_len     <= 1'b1;
      end
    end
  end

`ifdef SPI_ACQ_TIMESTAMP_EN
  // Free-running cycle counter, captured at the cycle a transfer start is seen.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ts_cnt <= 32'd0;
      ts_cap <= 32'd0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (start_xfer) ts_cap <= ts_cnt;
    end
  end
`endif

  // Frame FIFO pointers. Push and pop in one cycle leave the count unchanged.
  // The error path empties the queue outright.
  always_ff @(posedge i_clk) begin
    if (i_rst || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Frame storage, one entry per frame with its tlast flag in the top bit.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {push_last, push_data};
  end

  // The head entry is masked while the FIFO is empty so the stream outputs read 0
  // out of reset. It is stable while the beat waits for tready.
  assign {m_axis_tlast, m_axis_tdata} = fifo_empty ? '0 : mem[rd_ptr];
  assign m_axis_tvalid     = !fifo_empty;
  assign o_spi_en          = (state == ST_RUN) && frames_left;
  assign o_spi_buffer_full = buf_full_q;
  assign o_busy            = (state != ST_IDLE);
  assign o_frame_count     = frame_count;
  assign o_err_timeout     = err_timeout;
  assign o_err_len         = err_len;

endmodule

// File: tb/tb_spi_acq_sequencer.sv
// tb_spi_acq_sequencer
//   Directed bench for spi_acq_sequencer. The bench plays the SPI master and
//   the downstream sink. The expected values are hand-derived constants and
//   byte-pattern frames.
module tb_spi_acq_sequencer;

`ifdef SPI_ACQ_TIMESTAMP_EN
  localparam int FW = 80;
`else
  localparam int FW = 48;
`endif
  localparam int TMO = 100;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic          i_stop = 1'b0;
  logic [15:0]   i_num_frames = 16'd0;
  logic          o_spi_en;
  logic          o_spi_buffer_full;
  logic          i_spi_ready = 1'b1;
  logic          i_rx_byte_valid_tick = 1'b0;
  logic [7:0]    i_rx_byte = 8'h00;
  logic          i_transfer_done_tick = 1'b0;
  logic [FW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b0;
  logic          o_busy;
  logic [15:0]   o_frame_count;
  logic          o_err_timeout;
  logic          o_err_len;

  int passes = 0;
  int checks = 0;
  int cyc = 0;

  spi_acq_sequencer #(.BYTES_PER_XFER(6), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
    .i_num_frames(i_num_frames), .o_spi_en(o_spi_en), .o_spi_buffer_full(o_spi_buffer_full),
    .i_spi_ready(i_spi_ready), .i_rx_byte_valid_tick(i_rx_byte_valid_tick), .i_rx_byte(i_rx_byte),
    .i_transfer_done_tick(i_transfer_done_tick), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .o_busy(o_busy), .o_frame_count(o_frame_count), .o_err_timeout(o_err_timeout),
    .o_err_len(o_err_len)
  );

  // Free-running clock and cycle counter used to measure start-edge spacing.
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame built from six consecutive byte values, first byte in the MSB position.
  function automatic logic [47:0] expFrame(input logic [7:0] b);
    logic [47:0] f = '0;
    for (int i = 0; i < 6; i++) f = {f[39:0], b + 8'(i)};
    return f;
  endfunction

  task automatic pulseStart();
    i_start = 1'b1; step(); i_start = 1'b0;
  endtask

  task automatic pulseStop();
    i_stop = 1'b1; step(); i_stop = 1'b0;
  endtask

  // One SPI transfer of n bytes starting at value base. With overlap set, the
  // last byte strobe coincides with the done strobe. Returns just after the done edge.
  task automatic applyStimulus(input int n, input logic [7:0] base, input bit overlap);
    i_spi_ready = 1'b0;
    step();
    for (int i = 0; i < n; i++) begin
      i_rx_byte_valid_tick = 1'b1;
      i_rx_byte = base + 8'(i);
      i_transfer_done_tick = overlap && (i == n - 1);
      step();
      i_rx_byte_valid_tick = 1'b0;
      i_transfer_done_tick = 1'b0;
      if (i != n - 1) step();
    end
    if (!overlap) begin
      i_transfer_done_tick = 1'b1;
      step();
      i_transfer_done_tick = 1'b0;
    end
  endtask

  task automatic finishXfer();
    i_spi_ready = 1'b1;
    step();
    step();
  endtask

  initial begin
`ifdef SPI_ACQ_TIMESTAMP_EN
    int t1, t2;
    logic [31:0] ts_a, ts_b;
`endif
    // Reset
    step(); step();
    i_rst = 1'b0;
    step();
    checkOutput("rst_spi_en", 80'(o_spi_en), 80'(0));
    checkOutput("rst_buf_full", 80'(o_spi_buffer_full), 80'(0));
    checkOutput("rst_tvalid", 80'(m_axis_tvalid), 80'(0));
    checkOutput("rst_tdata", 80'(m_axis_tdata), 80'(0));
    checkOutput("rst_busy", 80'(o_busy), 80'(0));
    checkOutput("rst_fcount", 80'(o_frame_count), 80'(0));
    checkOutput("rst_errs", 80'({o_err_timeout, o_err_len, m_axis_tlast}), 80'(0));

    // T1: finite run of 3, sink always ready, num_frames changed after start
    $display("[TB] T1 finite run");
    m_axis_tready = 1'b1;
    i_num_frames = 16'd3;
    pulseStart();
    i_num_frames = 16'd1;
    checkOutput("t1_busy", 80'(o_busy), 80'(1));
    for (int k = 0; k < 3; k++) begin
      checkOutput("t1_spi_en", 80'(o_spi_en), 80'(1));
      applyStimulus(6, 8'h01, k == 1);
      checkOutput("t1_tvalid", 80'(m_axis_tvalid), 80'(1));
      checkOutput("t1_tdata", 80'(m_axis_tdata[47:0]), 80'(48'h010203040506));
      checkOutput("t1_tlast", 80'(m_axis_tlast), 80'(k == 2));
      checkOutput("t1_fcount", 80'(o_frame_count), 80'(k + 1));
      finishXfer();
    end
    checkOutput("t1_spi_en_off", 80'(o_spi_en), 80'(0));
    step(); step();
    checkOutput("t1_idle", 80'(o_busy), 80'(0));
    checkOutput("t1_empty", 80'(m_axis_tvalid), 80'(0));
    pulseStop();
    checkOutput("t1_stop_idle", 80'(o_busy), 80'(0));

    // T2: continuous with sink stalled, FIFO fills to depth 4
    $display("[TB] T2 back-pressure");
    m_axis_tready = 1'b0;
    i_num_frames = 16'd0;
    pulseStart();
    for (int k = 0; k < 4; k++) begin
      checkOutput("t2_spi_en", 80'(o_spi_en), 80'(1));
      checkOutput("t2_not_full", 80'(o_spi_buffer_full), 80'(0));
      applyStimulus(6, 8'(8'h10 * (k + 1)), 1'b0);
      finishXfer();
      if (k == 1) begin
        pulseStart();
        checkOutput("t2_start_ignored", 80'(o_frame_count), 80'(2));
      end
    end
    checkOutput("t2_fcount", 80'(o_frame_count), 80'(4));
    checkOutput("t2_full", 80'(o_spi_buffer_full), 80'(1));
    checkOutput("t2_tvalid", 80'(m_axis_tvalid), 80'(1));
    m_axis_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checkOutput("t2_beat", 80'(m_axis_tdata[47:0]), 80'(expFrame(8'(8'h10 * (k + 1)))));
      checkOutput("t2_tlast", 80'(m_axis_tlast), 80'(0));
      step();
    end
    checkOutput("t2_drained", 80'(m_axis_tvalid), 80'(0));
    step();
    checkOutput("t2_full_clear", 80'(o_spi_buffer_full), 80'(0));
    checkOutput("t2_resume", 80'(o_spi_en), 80'(1));

    // T3: short transfer flags a length error, run continues
    $display("[TB] T3 length error");
    applyStimulus(5, 8'hA0, 1'b0);
    checkOutput("t3_err_len", 80'(o_err_len), 80'(1));
    checkOutput("t3_no_push", 80'(o_frame_count), 80'(4));
    checkOutput("t3_no_beat", 80'(m_axis_tvalid), 80'(0));
    finishXfer();
    checkOutput("t3_busy", 80'(o_busy), 80'(1));
    checkOutput("t3_spi_en", 80'(o_spi_en), 80'(1));
    applyStimulus(6, 8'hB0, 1'b1);
    checkOutput("t3_fcount", 80'(o_frame_count), 80'(5));
    checkOutput("t3_tdata", 80'(m_axis_tdata[47:0]), 80'(expFrame(8'hB0)));
    checkOutput("t3_tlast", 80'(m_axis_tlast), 80'(0));
    finishXfer();

    // T4: watchdog with a frame queued
    $display("[TB] T4 watchdog");
    m_axis_tready = 1'b0;
    applyStimulus(6, 8'hD0, 1'b0);
    finishXfer();
    checkOutput("t4_queued", 80'(m_axis_tvalid), 80'(1));
    i_spi_ready = 1'b0;
    for (int i = 0; i < TMO - 5; i++) step();
    checkOutput("t4_no_tmo_yet", 80'(o_err_timeout), 80'(0));
    for (int i = 0; i < 15; i++) step();
    checkOutput("t4_err_tmo", 80'(o_err_timeout), 80'(1));
    checkOutput("t4_err_len_sticky", 80'(o_err_len), 80'(1));
    checkOutput("t4_busy", 80'(o_busy), 80'(1));
    checkOutput("t4_spi_en", 80'(o_spi_en), 80'(0));
    checkOutput("t4_flushed", 80'(m_axis_tvalid), 80'(0));
    pulseStop();
    checkOutput("t4_stop_ignored", 80'(o_busy), 80'(1));
    i_spi_ready = 1'b1;
    step(); step();
    pulseStart();
    checkOutput("t4_clr_tmo", 80'(o_err_timeout), 80'(0));
    checkOutput("t4_clr_len", 80'(o_err_len), 80'(0));
    checkOutput("t4_clr_fcount", 80'(o_frame_count), 80'(0));
    checkOutput("t4_resume", 80'(o_spi_en), 80'(1));

    // T5: stop in the middle of a transfer in continuous mode
    $display("[TB] T5 stop and reset");
    m_axis_tready = 1'b1;
    i_spi_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      i_rx_byte_valid_tick = 1'b1; i_rx_byte = 8'hC0 + 8'(i); step();
      i_rx_byte_valid_tick = 1'b0; step();
    end
    pulseStop();
    checkOutput("t5_spi_en_off", 80'(o_spi_en), 80'(0));
    checkOutput("t5_busy", 80'(o_busy), 80'(1));
    for (int i = 3; i < 6; i++) begin
      i_rx_byte_valid_tick = 1'b1; i_rx_byte = 8'hC0 + 8'(i);
      i_transfer_done_tick = (i == 5);
      step();
      i_rx_byte_valid_tick = 1'b0; i_transfer_done_tick = 1'b0;
      if (i < 5) step();
    end
    checkOutput("t5_fcount", 80'(o_frame_count), 80'(1));
    checkOutput("t5_tdata", 80'(m_axis_tdata[47:0]), 80'(expFrame(8'hC0)));
    i_spi_ready = 1'b1;
    step(); step(); step();
    checkOutput("t5_idle", 80'(o_busy), 80'(0));
    checkOutput("t5_empty", 80'(m_axis_tvalid), 80'(0));

    // Reset during a run, with the SPI transfer still running afterwards
    m_axis_tready = 1'b0;
    pulseStart();
    applyStimulus(6, 8'hE0, 1'b0);
    finishXfer();
    checkOutput("rr_pre_fcount", 80'(o_frame_count), 80'(1));
    i_spi_ready = 1'b0;
    step();
    i_rx_byte_valid_tick = 1'b1; i_rx_byte = 8'h77; step();
    i_rx_byte_valid_tick = 1'b0;
    i_rst = 1'b1;
    step();
    checkOutput("rr_busy", 80'(o_busy), 80'(0));
    checkOutput("rr_spi_en", 80'(o_spi_en), 80'(0));
    checkOutput("rr_fcount", 80'(o_frame_count), 80'(0));
    checkOutput("rr_tvalid", 80'(m_axis_tvalid), 80'(0));
    checkOutput("rr_tdata", 80'(m_axis_tdata), 80'(0));
    checkOutput("rr_flags", 80'({o_spi_buffer_full, o_err_timeout, o_err_len}), 80'(0));
    i_rst = 1'b0;
    pulseStart();
    applyStimulus(6, 8'h55, 1'b0);
    checkOutput("rr_ignored_fcount", 80'(o_frame_count), 80'(0));
    checkOutput("rr_ignored_len", 80'(o_err_len), 80'(0));
    checkOutput("rr_ignored_tvalid", 80'(m_axis_tvalid), 80'(0));
    finishXfer();
    pulseStop();
    step(); step();

`ifdef SPI_ACQ_TIMESTAMP_EN
    // T6: timestamp spacing of two back-to-back frames
    $display("[TB] T6 timestamp");
    pulseStart();
    t1 = cyc;
    applyStimulus(6, 8'h31, 1'b0);
    finishXfer();
    t2 = cyc;
    applyStimulus(6, 8'h41, 1'b0);
    finishXfer();
    checkOutput("t6_data0", 80'(m_axis_tdata[47:0]), 80'(expFrame(8'h31)));
    ts_a = m_axis_tdata[FW-1 -: 32];
    m_axis_tready = 1'b1;
    step();
    m_axis_tready = 1'b0;
    checkOutput("t6_data1", 80'(m_axis_tdata[47:0]), 80'(expFrame(8'h41)));
    ts_b = m_axis_tdata[FW-1 -: 32];
    checkOutput("t6_ts_gap", 80'(ts_b - ts_a), 80'(32'(t2 - t1)));
    pulseStop();
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
